// File: rtl/light_sequence_monitor.sv
// Receive-side checker for the cyclic RED->GREEN->YELLOW traffic-light code bus.
// Decodes lamps, enforces order and dwell limits, counts cycles, latches a sticky error.
module light_sequence_monitor #(
  parameter int unsigned MAX_DWELL = 8,
  parameter int unsigned DWELL_W   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         light_code,
  input  logic               code_valid,
  input  logic               clear_err,
  output logic [2:0]         lamp,
  output logic               in_sync,
  output logic               seq_error,
  output logic [1:0]         err_code,
  output logic [DWELL_W-1:0] dwell,
  output logic [CNT_W-1:0]   cycle_cnt
);

  typedef enum logic [1:0] {StSync, StTrack, StError} state_e;

  localparam logic [2:0] CodeRed    = 3'b000;
  localparam logic [2:0] CodeGreen  = 3'b001;
  localparam logic [2:0] CodeYellow = 3'b010;

  localparam logic [2:0] LampRed    = 3'b100;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrInvalid = 2'b01;
  localparam logic [1:0] ErrIllegal = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  localparam logic [DWELL_W-1:0] MaxDwell = DWELL_W'(MAX_DWELL);

  function automatic logic [2:0] lamp_of(input logic [2:0] code);
    unique case (code)
      CodeGreen:  lamp_of = 3'b001;
      CodeYellow: lamp_of = 3'b010;
      default:    lamp_of = LampRed;
    endcase
  endfunction

  function automatic logic [2:0] next_of(input logic [2:0] code);
    unique case (code)
      CodeRed:    next_of = CodeGreen;
      CodeGreen:  next_of = CodeYellow;
      default:    next_of = CodeRed;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         lamp_q, lamp_d;
  logic               in_sync_q, in_sync_d;
  logic               seq_error_q, seq_error_d;
  logic [1:0]         err_q, err_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic       go_err;
  logic [1:0] cause;
  logic       code_bad;

  assign code_bad = (light_code > CodeYellow);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    lamp_d  = lamp_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    go_err  = 1'b0;
    cause   = ErrNone;

    if (clear_err) begin
      // Clear wins over any sample presented in the same cycle.
      state_d = StSync;
      last_d  = CodeRed;
      lamp_d  = LampRed;
      dwell_d = '0;
      err_d   = ErrNone;
    end else if (code_valid) begin
      unique case (state_q)
        StSync: begin
          if (light_code == CodeRed) begin
            state_d = StTrack;
            last_d  = CodeRed;
            dwell_d = DWELL_W'(1);
            lamp_d  = LampRed;
          end else if (code_bad) begin
            go_err = 1'b1;
            cause  = ErrInvalid;
          end else begin
            dwell_d = '0;
          end
        end
        StTrack: begin
          if (code_bad) begin
            go_err = 1'b1;
            cause  = ErrInvalid;
          end else if (light_code == last_q) begin
            if (dwell_q == MaxDwell) begin
              go_err = 1'b1;
              cause  = ErrTimeout;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end else if (light_code == next_of(last_q)) begin
            last_d  = light_code;
            dwell_d = DWELL_W'(1);
            lamp_d  = lamp_of(light_code);
            if (last_q == CodeYellow) cnt_d = cnt_q + 1'b1;
          end else begin
            go_err = 1'b1;
            cause  = ErrIllegal;
          end
        end
        default: ;
      endcase

      if (go_err) begin
        state_d = StError;
        err_d   = cause;
        dwell_d = '0;
        lamp_d  = LampRed;
      end
    end

    in_sync_d   = (state_d == StTrack);
    seq_error_d = (state_d == StError);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StSync;
      last_q      <= CodeRed;
      lamp_q      <= LampRed;
      in_sync_q   <= 1'b0;
      seq_error_q <= 1'b0;
      err_q       <= ErrNone;
      dwell_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lamp_q      <= lamp_d;
      in_sync_q   <= in_sync_d;
      seq_error_q <= seq_error_d;
      err_q       <= err_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
    end
  end

  assign lamp      = lamp_q;
  assign in_sync   = in_sync_q;
  assign seq_error = seq_error_q;
  assign err_code  = err_q;
  assign dwell     = dwell_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: doc/light_sequence_monitor.md
Name: light_sequence_monitor

Overview:
- Receive-side checker for the 3-bit cyclic traffic-light code bus driven by the light-sequencer FSM.
- Samples the code each valid cycle and decodes it to one-hot lamp drives.
- Enforces the legal RED -> GREEN -> YELLOW -> RED order and a maximum dwell per light. Counts completed cycles.
- Latches a sticky error with a cause code for the supervisory logic.

Parameters:
- MAX_DWELL, 8, maximum consecutive valid samples of one code before a timeout error (1..2^DWELL_W-1).
- DWELL_W, 4, width of the dwell counter.
- CNT_W, 8, width of the completed-cycle counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- light_code  input  3  light code. RED=3'b000, GREEN=3'b001, YELLOW=3'b010. 3'b011-3'b111 are invalid.
- code_valid  input  1  light_code is sampled only when high.
- clear_err  input  1  one-cycle pulse: clears sticky error and resynchronises.
- lamp  output  3  one-hot lamp drive {red, yellow, green}.
- in_sync  output  1  high while in TRACK.
- seq_error  output  1  sticky error flag.
- err_code  output  2  error cause: 00 none, 01 invalid code, 10 illegal transition, 11 dwell timeout.
- dwell  output  DWELL_W  consecutive valid samples of the current code.
- cycle_cnt  output  CNT_W  completed YELLOW->RED transitions; wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered. Effect of a sample is visible the cycle after the sampling edge (latency 1).
- Reset (reset=0, asynchronous):
  - state=SYNC, lamp=3'b100, in_sync=0, seq_error=0, err_code=00, dwell=0, cycle_cnt=0.
  - Internal last_code=RED.
  - Reset asserted mid-operation aborts everything immediately.
- State machine: SYNC, TRACK, ERROR.
- code_valid=0: no state change. dwell, lamp and cycle_cnt hold. clear_err is still honoured.
- SYNC:
  - Valid RED -> TRACK, last_code=RED, dwell=1, lamp=3'b100.
  - Valid GREEN or YELLOW -> ignored; stay in SYNC with dwell=0.
  - Valid invalid code -> ERROR, err_code=01.
- TRACK, one valid sample per cycle, checks evaluated in this priority order:
  1. Invalid code -> ERROR, err_code=01.
  2. Same as last_code:
     - if dwell==MAX_DWELL -> ERROR, err_code=11;
     - else dwell+1.
  3. Legal successor (RED->GREEN, GREEN->YELLOW, YELLOW->RED): last_code=new, dwell=1, lamp updated.
     - On YELLOW->RED, cycle_cnt+1, wrapping to 0 after all-ones.
  4. Any other change (e.g. RED->YELLOW, GREEN->RED, YELLOW->GREEN) -> ERROR, err_code=10.
- ERROR:
  - seq_error=1, in_sync=0, lamp=3'b100 (fail-safe red), dwell=0.
  - cycle_cnt holds; err_code holds the first cause.
  - Further samples are ignored.
- clear_err:
  - In any state it wins over the sample that cycle, and that sample is discarded.
  - Next state=SYNC, seq_error=0, err_code=00, dwell=0, lamp=3'b100.
  - cycle_cnt is not cleared.
- Lamp encoding: RED -> 3'b100, YELLOW -> 3'b010, GREEN -> 3'b001. Never more than one bit set.
- dwell never exceeds MAX_DWELL; it saturates into the timeout error.

Test Plan:
- Reset, then valid RED,GREEN,YELLOW repeated 3x followed by RED -> in_sync=1 one cycle after first RED; lamp sequence 100,001,010; cycle_cnt=3; seq_error=0.
- From SYNC send GREEN,YELLOW,RED,GREEN -> stays SYNC for first two samples (lamp=100, dwell=0); in_sync=1 after RED; lamp=001 after GREEN.
- In TRACK after RED, send YELLOW -> seq_error=1, err_code=10, lamp=100. Then pulse clear_err alongside a RED sample -> SYNC, err_code=00, that RED ignored, cycle_cnt unchanged.
- MAX_DWELL=8: valid GREEN held 9 consecutive samples after RED -> dwell reaches 8, 9th sample gives err_code=11. With code_valid low for 5 cycles in between, dwell holds and there is no error.
- Invalid code 3'b101 in TRACK -> err_code=01. Subsequent illegal transitions leave err_code=01 (first cause held).
- CNT_W=2: 5 full cycles -> cycle_cnt 1,2,3,0,1. Assert reset mid-GREEN -> all outputs return to reset values asynchronously, before the next clock edge.
